display_scheduler: RTL and testbench

//  Shares the single 4-digit 7-segment state_display between N_REQ producers
//  (FSM state, trigger status, error codes, measurement bytes).

---
 rtl/disp_sched_pkg.sv | 20 ++
 rtl/disp_sched_if.sv | 29 ++
 rtl/disp_rr_pick.sv | 28 ++
 rtl/display_scheduler.sv | 142 ++++++++++++++
 tb/tb_display_scheduler.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/disp_sched_pkg.sv
// Shared types and defaults for the display scheduler.
// Optional feature macro used by the top: DISP_SCHED_PRIO_EN (slot 0 urgent).
package disp_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } sched_state_t;

  localparam int DEF_N_REQ       = 4;
  localparam int DEF_DATA_W      = 8;
  localparam int SIM_HOLD_CYCLES = 4;

  // Cyclic successor of a slot index.
  function automatic int next_slot(input int id, input int n);
    return (id + 1) % n;
  endfunction

endpackage

// File: rtl/disp_sched_if.sv
// Producer <-> scheduler <-> state_display signal bundle.
interface disp_sched_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8
);
  localparam int ID_W = $clog2(N_REQ);

  // req_valid[i] is a 1-cycle post strobe with no backpressure; the scheduler
  // always accepts it. req_ack[i] pulses once when slot i's value is issued,
  // coincident with state_change, regardless of how many posts preceded it.
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_ack;
  logic [DATA_W-1:0]       state;
  logic                    state_change;
  logic [ID_W-1:0]         active_id;
  logic                    busy;

  modport master (
    output req_valid, req_data,
    input  req_ack, state, state_change, active_id, busy
  );

  modport slave (
    input  req_valid, req_data,
    output req_ack, state, state_change, active_id, busy
  );

endinterface

// File: rtl/disp_rr_pick.sv
// Combinational cyclic first-set search starting at i_rr_ptr.
module disp_rr_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_pending,
  input  logic [ID_W-1:0]  i_rr_ptr,
  output logic [ID_W-1:0]  o_grant_id,
  output logic             o_grant_any
);

  logic [ID_W-1:0] w_idx;

  // Scan from the farthest offset down so the nearest pending slot wins.
  always_comb begin
    o_grant_id  = '0;
    o_grant_any = 1'b0;
    w_idx       = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_idx = ID_W'((int'(i_rr_ptr) + k) % N_REQ);
      if (i_pending[w_idx]) begin
        o_grant_id  = w_idx;
        o_grant_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/display_scheduler.sv
// Time-shares state_display between N_REQ producers with a minimum hold time.
// Optional: define DISP_SCHED_PRIO_EN to make slot 0 urgent (preempts a hold).
module display_scheduler
  import disp_sched_pkg::*;
#(
  parameter int N_REQ       = DEF_N_REQ,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int HOLD_CYCLES = 50_000_000
) (
  input  logic         clk,
  input  logic         rst,
  disp_sched_if.slave  bus,
  output sched_state_t o_dbg_state
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

  sched_state_t      r_fsm;
  logic [N_REQ-1:0]  r_pending;
  logic [DATA_W-1:0] r_slot_data [N_REQ];
  logic [ID_W-1:0]   r_rr_ptr;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_disp;
  logic              r_change;
  logic [N_REQ-1:0]  r_ack;
  logic [ID_W-1:0]   r_active_id;
  logic              r_busy;

  logic [ID_W-1:0]   w_rr_id;
  logic              w_rr_any;
  logic [ID_W-1:0]   w_sel_id;
  logic              w_sel_any;
  logic              w_abort;
  logic              w_adv_rr;
  logic [N_REQ-1:0]  w_clr;

  disp_rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .i_pending   (r_pending),
    .i_rr_ptr    (r_rr_ptr),
    .o_grant_id  (w_rr_id),
    .o_grant_any (w_rr_any)
  );

  always_comb begin
`ifdef DISP_SCHED_PRIO_EN
    w_sel_id  = r_pending[0] ? '0 : w_rr_id;
    w_sel_any = r_pending[0] | w_rr_any;
    w_abort   = r_pending[0] && (r_active_id != '0);
    // Urgent slot-0 grants leave the round-robin order untouched.
    w_adv_rr  = (r_active_id != '0);
`else
    w_sel_id  = w_rr_id;
    w_sel_any = w_rr_any;
    w_abort   = 1'b0;
    w_adv_rr  = 1'b1;
`endif
  end

  always_comb begin
    w_clr = '0;
    if (r_fsm == IDLE && w_sel_any) begin
      w_clr[w_sel_id] = 1'b1;
    end
  end

  // A post landing on the grant edge re-arms pending with the new data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending <= '0;
      for (int i = 0; i < N_REQ; i++) begin
        r_slot_data[i] <= '0;
      end
    end else begin
      r_pending <= (r_pending & ~w_clr) | bus.req_valid;
      for (int i = 0; i < N_REQ; i++) begin
        if (bus.req_valid[i]) begin
          r_slot_data[i] <= bus.req_data[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fsm       <= IDLE;
      r_rr_ptr    <= '0;
      r_cnt       <= '0;
      r_disp      <= '0;
      r_change    <= 1'b0;
      r_ack       <= '0;
      r_active_id <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_change <= 1'b0;
      r_ack    <= '0;
      case (r_fsm)
        IDLE: begin
          if (w_sel_any) begin
            r_disp      <= r_slot_data[w_sel_id];
            r_active_id <= w_sel_id;
            r_busy      <= 1'b1;
            r_fsm       <= ISSUE;
          end
        end
        ISSUE: begin
          r_change           <= 1'b1;
          r_ack[r_active_id] <= 1'b1;
          r_cnt              <= HOLD_LOAD;
          if (w_adv_rr) begin
            r_rr_ptr <= ID_W'(next_slot(int'(r_active_id), N_REQ));
          end
          r_fsm <= HOLD;
        end
        HOLD: begin
          if (w_abort || r_cnt == '0) begin
            r_busy <= 1'b0;
            r_fsm  <= IDLE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: begin
          r_busy <= 1'b0;
          r_fsm  <= IDLE;
        end
      endcase
    end
  end

  assign bus.state        = r_disp;
  assign bus.state_change = r_change;
  assign bus.req_ack      = r_ack;
  assign bus.active_id    = r_active_id;
  assign bus.busy         = r_busy;
  assign o_dbg_state      = r_fsm;

endmodule

// File: tb/tb_display_scheduler.sv
// Bench for display_scheduler: event-level reference model + scoreboard.
module tb_display_scheduler;
  import disp_sched_pkg::*;

  localparam int N    = 4;
  localparam int DW   = 8;
  localparam int HOLD = SIM_HOLD_CYCLES;

  logic         clk = 1'b0;
  logic         rst;
  sched_state_t dbg_state;

  disp_sched_if #(.N_REQ(N), .DATA_W(DW)) bus ();

  display_scheduler #(
    .N_REQ       (N),
    .DATA_W      (DW),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit mon_en   = 1'b0;

  // {pulse cycle[31:10], slot id[9:8], data[7:0]}
  logic [31:0] exp_q[$];

  // ---------------- reference model (timeline of grants) ----------------
  logic [N-1:0]  m_pend;
  logic [DW-1:0] m_data [N];
  int            m_rr, m_free_at, m_g, m_cur;
  bit            m_busy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=0x%0h required=0x%0h", name, cyc, act, req);
    end
  endtask

  task automatic model_step();
    int e;
    int gid;
    e = cyc;
    if (rst) begin
      m_pend = '0;
      for (int i = 0; i < N; i++) m_data[i] = '0;
      m_rr = 0; m_free_at = 0; m_g = 0; m_cur = 0; m_busy = 1'b0;
      return;
    end
`ifdef DISP_SCHED_PRIO_EN
    if (m_busy && e >= m_g + 2 && m_pend[0] && m_cur != 0) begin
      m_busy    = 1'b0;
      m_free_at = e + 1;
    end
`endif
    if (m_busy && e == m_g + HOLD + 1) m_busy = 1'b0;
    if (e >= m_free_at && m_pend != '0) begin
      gid = -1;
`ifdef DISP_SCHED_PRIO_EN
      if (m_pend[0]) gid = 0;
`endif
      for (int k = 0; k < N; k++) begin
        if (gid < 0 && m_pend[(m_rr + k) % N]) gid = (m_rr + k) % N;
      end
      exp_q.push_back({22'(e + 1), 2'(gid), m_data[gid]});
      m_pend[gid] = 1'b0;
      m_g = e; m_cur = gid; m_busy = 1'b1;
      m_free_at = e + HOLD + 2;
`ifdef DISP_SCHED_PRIO_EN
      if (gid != 0) m_rr = (gid + 1) % N;
`else
      m_rr = (gid + 1) % N;
`endif
    end
    for (int i = 0; i < N; i++) begin
      if (bus.req_valid[i]) begin
        m_data[i] = bus.req_data[i*DW +: DW];
        m_pend[i] = 1'b1;
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      model_step();
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (mon_en && !rst) begin
        chk("busy", 32'(bus.busy), 32'(m_busy));
        if (bus.state_change === 1'b1) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_pulse cyc=%0d state=0x%0h id=%0d", cyc, bus.state, bus.active_id);
          end else begin
            e = exp_q.pop_front();
            chk("pulse_cycle", 32'(cyc), 32'(e[31:10]));
            chk("active_id", 32'(bus.active_id), 32'(e[9:8]));
            chk("state", 32'(bus.state), 32'(e[7:0]));
            chk("req_ack", 32'(bus.req_ack), 32'(1 << e[9:8]));
          end
        end else begin
          chk("ack_idle", 32'(bus.req_ack), 32'd0);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [N*DW-1:0] slot_word(input int slot, input logic [DW-1:0] d);
    logic [N*DW-1:0] r;
    r = '0;
    r[slot*DW +: DW] = d;
    return r;
  endfunction

  task automatic post(input logic [N-1:0] v, input logic [N*DW-1:0] d);
    bus.req_valid = v;
    bus.req_data  = d;
    @(posedge clk);
    #1;
    bus.req_valid = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_quiet();
    int b;
    b = 0;
    while (!(exp_q.size() == 0 && !m_busy && m_pend == '0) && b < 300) begin
      @(posedge clk);
      #1;
      b++;
    end
    checks++;
    if (b >= 300) begin
      failures++;
      $display("FAIL quiesce_timeout cyc=%0d actual=%0d required<300 pending_exp=%0d", cyc, b, exp_q.size());
    end
    idle(1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_state"}, 32'(bus.state), 32'd0);
    chk({tag, "_state_change"}, 32'(bus.state_change), 32'd0);
    chk({tag, "_req_ack"}, 32'(bus.req_ack), 32'd0);
    chk({tag, "_active_id"}, 32'(bus.active_id), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_fsm"}, 32'(dbg_state), 32'(IDLE));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [N-1:0]    v;
    logic [N*DW-1:0] d;
    int              rate;
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_outputs("por");
    mon_en = 1'b1;

    // single post, idle scheduler
    post(4'b0100, slot_word(2, 8'h5A));
    wait_quiet();

    // three simultaneous posts served in round-robin order
    post(4'b1011, {8'hD3, 8'h00, 8'hB1, 8'hA0});
    wait_quiet();

    // overwrite while another slot holds: latest data, one ack
    post(4'b0001, slot_word(0, 8'h30));
    idle(2);
    post(4'b0010, slot_word(1, 8'h11));
    idle(1);
    post(4'b0010, slot_word(1, 8'h22));
    wait_quiet();

    // slot 0 posts while slot 2 is holding
    post(4'b0100, slot_word(2, 8'h77));
    idle(3);
    post(4'b0001, slot_word(0, 8'hEE));
    wait_quiet();

    // post on the grant edge of the same slot
    post(4'b1000, slot_word(3, 8'h3C));
    post(4'b1000, slot_word(3, 8'hA5));
    wait_quiet();

    // reset mid-hold with a request pending and a non-zero rr pointer
    post(4'b0100, slot_word(2, 8'h44));
    post(4'b0010, slot_word(1, 8'h55));
    idle(2);
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    exp_q.delete();
    idle(2);
    rst = 1'b0;
    post(4'b1111, {8'h04, 8'h03, 8'h02, 8'h01});
    wait_quiet();

    // randomized posts at varying densities
    for (int blk = 0; blk < 6; blk++) begin
      rate = $urandom_range(2, 20);
      repeat (250) begin
        v = '0;
        for (int i = 0; i < N; i++) begin
          if ($urandom_range(0, rate - 1) == 0) v[i] = 1'b1;
        end
        d = $urandom();
        post(v, d);
      end
    end
    wait_quiet();
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
